// File: rtl/rsa_fifo_sequencer.sv
// Sequencer between the AHB-to-FIFO bridge and the RSA core: loads one M/E/N operand
// frame into the core operand RAMs, starts the core, then streams the result back out.
module rsa_fifo_sequencer #(
    parameter int NW = 32,
    parameter int AW = 5
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          start,
    input  logic          abort,
    input  logic          frd_vld,
    output logic          frd_rdy,
    input  logic [31:0]   frd_dat,
    output logic          op_we,
    output logic [1:0]    op_sel,
    output logic [AW-1:0] op_addr,
    output logic [31:0]   op_wdata,
    output logic          core_start,
    input  logic          core_done,
    output logic          res_rd,
    output logic [AW-1:0] res_addr,
    input  logic [31:0]   res_rdata,
    output logic          bwr_vld,
    input  logic          bwr_rdy,
    output logic [31:0]   bwr_dat,
    output logic          busy,
    output logic          finish,
    output logic [3:0]    dbg_state
);

    // Handshakes: a word moves on a rising edge where valid & ready are both high;
    // bwr_vld/bwr_dat stay stable until accepted, frd_rdy never depends on frd_vld.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_SETTLE = 4'd2,
        S_RUN    = 4'd3,
        S_WAIT   = 4'd4,
        S_READ   = 4'd5,
        S_CAP    = 4'd6,
        S_PUSH   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    localparam logic [AW-1:0] LAST_W   = AW'(NW - 1);
    localparam logic [1:0]    LAST_SEL = 2'd2;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    sel;
    logic [AW-1:0] wcnt;
    logic          last_word;

    assign last_word = (wcnt == LAST_W);
    assign dbg_state = state;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_nxt = S_LOAD;
                S_LOAD:   if (frd_vld && (sel == LAST_SEL) && last_word) state_nxt = S_SETTLE;
                S_SETTLE: state_nxt = S_RUN;
                S_RUN:    state_nxt = S_WAIT;
                S_WAIT:   if (core_done) state_nxt = S_READ;
                S_READ:   state_nxt = S_CAP;
                S_CAP:    state_nxt = S_PUSH;
                S_PUSH:   if (bwr_rdy) state_nxt = last_word ? S_DONE : S_READ;
                S_DONE:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        frd_rdy    = (state == S_LOAD);
        core_start = (state == S_RUN);
        res_rd     = (state == S_READ);
        res_addr   = (state == S_READ) ? wcnt : '0;
        bwr_vld    = (state == S_PUSH);
        busy       = (state != S_IDLE);
        finish     = (state == S_DONE);
    end

    // Operand write port is registered so op_we trails its FIFO transfer by one cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel      <= '0;
            wcnt     <= '0;
            op_we    <= 1'b0;
            op_sel   <= '0;
            op_addr  <= '0;
            op_wdata <= '0;
            bwr_dat  <= '0;
        end else begin
            op_we <= 1'b0;
            if (abort) begin
                sel  <= '0;
                wcnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        sel  <= '0;
                        wcnt <= '0;
                    end
                    S_LOAD: begin
                        if (frd_vld) begin
                            op_we    <= 1'b1;
                            op_wdata <= frd_dat;
                            op_sel   <= sel;
                            op_addr  <= wcnt;
                            if (last_word) begin
                                wcnt <= '0;
                                sel  <= sel + 2'd1;
                            end else begin
                                wcnt <= wcnt + 1'b1;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (core_done) wcnt <= '0;
                    end
                    S_CAP: begin
                        bwr_dat <= res_rdata;
                    end
                    S_PUSH: begin
                        if (bwr_rdy) wcnt <= last_word ? '0 : wcnt + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rsa_fifo_sequencer.sv
// Randomized frame-level bench for rsa_fifo_sequencer: FIFO, core and result RAM models
// plus an expected-write and expected-result scoreboard.
module tb_rsa_fifo_sequencer;

    localparam int NW = 2;
    localparam int AW = 2;
    localparam int WW = 34 + AW;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          start;
    logic          abort;
    logic          frd_vld;
    logic          frd_rdy;
    logic [31:0]   frd_dat;
    logic          op_we;
    logic [1:0]    op_sel;
    logic [AW-1:0] op_addr;
    logic [31:0]   op_wdata;
    logic          core_start;
    logic          core_done;
    logic          res_rd;
    logic [AW-1:0] res_addr;
    logic [31:0]   res_rdata;
    logic          bwr_vld;
    logic          bwr_rdy;
    logic [31:0]   bwr_dat;
    logic          busy;
    logic          finish;
    logic [3:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    logic [31:0]   fifo_q[$];
    logic [WW-1:0] exp_q[$];
    logic [31:0]   exp_res_q[$];

    rsa_fifo_sequencer #(.NW(NW), .AW(AW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort),
        .frd_vld(frd_vld), .frd_rdy(frd_rdy), .frd_dat(frd_dat),
        .op_we(op_we), .op_sel(op_sel), .op_addr(op_addr), .op_wdata(op_wdata),
        .core_start(core_start), .core_done(core_done),
        .res_rd(res_rd), .res_addr(res_addr), .res_rdata(res_rdata),
        .bwr_vld(bwr_vld), .bwr_rdy(bwr_rdy), .bwr_dat(bwr_dat),
        .busy(busy), .finish(finish), .dbg_state(dbg_state)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {frd_rdy, op_we, op_sel, op_addr, core_start, res_rd,
                               res_addr, bwr_vld, busy, finish}, 0);
        check({tag, "_data"}, {op_wdata, bwr_dat}, 0);
    endtask

    // gap: 0 held, 1 toggled, 2 random; bp: 0 none, 1 seven-cycle stall on first push, 2 random
    task automatic run_frame(input int gap, input int bp, input int dly, input int spur,
                             input int abort_at, input int rst_push, input int fixed);
        logic [31:0]   w;
        logic [31:0]   res_mem [NW];
        logic [31:0]   hold_dat;
        logic [AW-1:0] pend_addr;
        int cyc, load_cyc, last_we_cyc, fin_cyc, n_start, n_fin, acc_n, xfer_n;
        int done_cnt, bp_left, first_vld_n, tail;
        bit tog, aborted, hold_p, rd_p, bp_used, ended, rst_done;

        fifo_q.delete();
        exp_q.delete();
        exp_res_q.delete();
        for (int i = 0; i < 3 * NW; i++) begin
            w = (fixed != 0) ? 32'h10 + 32'(i) : $urandom;
            fifo_q.push_back(w);
            exp_q.push_back({2'(i / NW), AW'(i % NW), w});
        end
        for (int k = 0; k < NW; k++) begin
            res_mem[k] = (fixed != 0) ? 32'hA0 + 32'(k) : $urandom;
            exp_res_q.push_back(res_mem[k]);
        end
        cyc = 0; load_cyc = -1; last_we_cyc = -10; fin_cyc = -10; n_start = 0; n_fin = 0;
        acc_n = 0; xfer_n = 0; done_cnt = 0; bp_left = 0; first_vld_n = 0; tail = 0;
        tog = 1; aborted = 0; hold_p = 0; rd_p = 0; bp_used = 0; ended = 0; rst_done = 0;
        pend_addr = '0; hold_dat = '0;
        start = 1'b1;

        while (!ended) begin
            @(negedge HCLK);
            cyc++;
            core_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) core_done = 1'b1;
            end
            if (spur != 0 && frd_rdy && $urandom_range(0, 2) == 0) core_done = 1'b1;

            if (aborted) begin
                tail++;
                if (tail == 1) begin
                    check("abort_busy", busy, 0);
                    check("abort_rdy", frd_rdy, 0);
                end
                if (tail == 4) ended = 1;
            end
            if (hold_p) check("bwr_hold", {bwr_vld, bwr_dat}, {1'b1, hold_dat});
            hold_p = 0;
            if (busy && load_cyc < 0) load_cyc = cyc;

            if (op_we) begin
                if (exp_q.size() == 0) check("op_we_extra", 1, 0);
                else check("op_write", {op_sel, op_addr, op_wdata}, exp_q.pop_front());
                last_we_cyc = cyc;
            end
            if (core_start) begin
                n_start++;
                check("start_lag", cyc - last_we_cyc, 1);
                done_cnt = dly;
            end
            start = (load_cyc < 0) ? 1'b1 :
                    (spur != 0 && n_start == 1 && done_cnt > 0) ? 1'($urandom_range(0, 1)) : 1'b0;

            // Result RAM: one-cycle read latency, garbage when no read is outstanding.
            res_rdata = rd_p ? res_mem[pend_addr] : $urandom;
            rd_p = res_rd;
            if (res_rd) begin
                pend_addr = res_addr;
                check("res_addr", res_addr, acc_n);
            end

            if (bwr_vld && acc_n == 0) first_vld_n++;
            if (bp == 1 && bwr_vld && !bp_used) begin
                bp_used = 1;
                bp_left = 7;
            end
            if (bp_left > 0) begin
                bwr_rdy = 1'b0;
                bp_left--;
            end else if (bp == 2) begin
                bwr_rdy = 1'($urandom_range(0, 1));
            end else begin
                bwr_rdy = 1'b1;
            end
            if (rst_push != 0 && bwr_vld) bwr_rdy = 1'b0;
            if (bwr_vld) begin
                if (bwr_rdy) begin
                    if (exp_res_q.size() == 0) check("bwr_extra", 1, 0);
                    else check("bwr_dat", bwr_dat, exp_res_q.pop_front());
                    acc_n++;
                end else begin
                    hold_p = 1;
                    hold_dat = bwr_dat;
                end
            end

            if (finish) begin
                n_fin++;
                fin_cyc = cyc;
                check("finish_busy", busy, 1);
                if (gap == 0 && bp == 0) check("frame_len", cyc - load_cyc + 1, 6 * NW + 3 + dly);
            end else if (n_fin > 0 && cyc == fin_cyc + 1) begin
                check("post_busy", busy, 0);
                check("post_finish", finish, 0);
                ended = 1;
            end

            if (gap == 0) frd_vld = (fifo_q.size() > 0);
            else if (gap == 1) begin
                frd_vld = tog && (fifo_q.size() > 0);
                tog = !tog;
            end else frd_vld = (fifo_q.size() > 0) && ($urandom_range(0, 1) == 1);
            frd_dat = frd_vld ? fifo_q[0] : $urandom;
            abort = 1'b0;
            if (abort_at > 0 && !aborted && xfer_n == abort_at) begin
                abort = 1'b1;
                aborted = 1;
                exp_q.delete();
            end
            if (frd_vld && frd_rdy) begin
                void'(fifo_q.pop_front());
                xfer_n++;
            end
            if (aborted) fifo_q.delete();

            if (rst_push != 0 && bwr_vld && !rst_done) begin
                rst_done = 1;
                #3 HRESET = 1'b1;
                #1 check_zero("reset_push");
                start = 1'b0; frd_vld = 1'b0; core_done = 1'b0; bwr_rdy = 1'b0;
                @(negedge HCLK);
                check_zero("reset_hold");
                HRESET = 1'b0;
                ended = 1;
            end
            if (cyc > 400) begin
                check("timeout", cyc, 0);
                ended = 1;
            end
        end

        start = 1'b0; abort = 1'b0; frd_vld = 1'b0; core_done = 1'b0;
        if (abort_at > 0) begin
            check("abort_starts", n_start, 0);
            check("abort_finish", n_fin, 0);
        end else if (rst_push != 0) begin
            check("rst_starts", n_start, 1);
        end else begin
            check("writes_left", exp_q.size(), 0);
            check("results_left", exp_res_q.size(), 0);
            check("core_starts", n_start, 1);
            check("finishes", n_fin, 1);
            if (bp == 1) check("bp_vld_cycles", first_vld_n, 8);
        end
    endtask

    initial begin
        HRESET = 1'b1; start = 1'b0; abort = 1'b0; frd_vld = 1'b0; frd_dat = '0;
        core_done = 1'b0; res_rdata = '0; bwr_rdy = 1'b0;
        #1 check_zero("reset_async");
        repeat (3) @(negedge HCLK);
        check_zero("reset");
        HRESET = 1'b0;
        @(negedge HCLK);
        check_zero("idle");

        run_frame(0, 0, 5, 0, 0, 0, 1);
        run_frame(1, 0, 5, 0, 0, 0, 1);
        run_frame(0, 1, 3, 0, 0, 0, 1);
        run_frame(0, 0, 4, 1, 0, 0, 1);
        run_frame(0, 0, 3, 0, 3, 0, 0);
        run_frame(0, 0, 2, 0, 0, 0, 0);
        run_frame(0, 0, 2, 0, 0, 1, 0);
        run_frame(0, 0, 1, 0, 0, 0, 0);
        for (int r = 0; r < 10; r++) begin
            run_frame(int'($urandom_range(0, 2)), 2 * int'($urandom_range(0, 1)),
                      int'($urandom_range(1, 6)), int'($urandom_range(0, 1)), 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        check("watchdog", 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_fifo_sequencer.md
# rsa_fifo_sequencer

Sequencer between the AHB-to-FIFO slave bridge and the RSA modular-exponentiation core. On a start request it drains one operand frame (message M, exponent E, modulus N; NW words each) from the forward FIFO into the core's operand RAMs and pulses the core start. It then waits for core completion and streams the NW-word result from the core's result RAM into the backward FIFO. It finishes with a one-cycle finish pulse that the bridge latches into its status register.

## Interface
- `NW`, 32: words per operand (32 → 1024-bit); legal 2..256.
- `AW`, 5: operand/result RAM address width; must satisfy 2^AW ≥ NW.
- `HCLK` in 1: single clock, shared with the AHB bridge.
- `HRESET` in 1: asynchronous, active-high reset.
- `start` in 1: start request (level); sampled only in IDLE.
- `abort` in 1: synchronous soft clear, any state.
- `frd_vld` in 1: forward FIFO has a word.
- `frd_rdy` out 1: sequencer accepts a word; transfer when `frd_vld & frd_rdy`.
- `frd_dat` in 32: forward FIFO word.
- `op_we` out 1: operand RAM write strobe.
- `op_sel` out 2: operand select; 0=M, 1=E, 2=N.
- `op_addr` out AW: operand word index, 0 = least-significant word.
- `op_wdata` out 32: operand write data.
- `core_start` out 1: one-cycle start pulse to the RSA core.
- `core_done` in 1: core completion pulse/level.
- `res_rd` out 1: result RAM read strobe; data valid the next cycle.
- `res_addr` out AW: result word index.
- `res_rdata` in 32: result RAM read data.
- `bwr_vld` out 1: backward FIFO write request.
- `bwr_rdy` in 1: backward FIFO not full; write occurs when `bwr_vld & bwr_rdy`.
- `bwr_dat` out 32: result word to the backward FIFO.
- `busy` out 1: high whenever state ≠ IDLE.
- `finish` out 1: one-cycle pulse at end of frame.

## Operation
- States: IDLE, LOAD, SETTLE, RUN, WAIT, READ, CAP, PUSH, DONE.
- **IDLE:** `start=1` → LOAD. Clear sel counter (2 bit) and word counter (AW bit).
- **LOAD:** `frd_rdy=1`, decoded combinationally from the state register.
  - Each transfer registers `op_wdata=frd_dat`, `op_sel=sel`, `op_addr=wcnt`, and asserts `op_we=1` for the following cycle.
  - `wcnt` increments per transfer and wraps to 0 at NW-1, at which point `sel` increments.
  - The transfer with `sel=2, wcnt=NW-1` → SETTLE.
  - `frd_vld=0` stalls; there is no timeout.
- **SETTLE:** carries the final `op_we`; → RUN.
- **RUN:** `core_start=1` for exactly this cycle; → WAIT.
- **WAIT:** `core_done=1` → READ, with `wcnt=0`.
- **READ:** `res_rd=1`, `res_addr=wcnt`; → CAP.
- **CAP:** `bwr_dat <= res_rdata`; → PUSH.
- **PUSH:** `bwr_vld=1`, held with `bwr_dat` stable until `bwr_rdy=1`.
  - On the accepted write, `wcnt++`.
  - Last word (`wcnt=NW-1`) → DONE; otherwise → READ.
- **DONE:** `finish=1` for one cycle; → IDLE.
- Word order: least-significant first, both in and out.
- Ignored events:
  - `start` outside IDLE.
  - `core_done` outside WAIT.
  - `frd_vld` outside LOAD; no pop occurs.
- Abort: `abort=1` in any state → IDLE on the next edge.
  - All strobes (`op_we`, `core_start`, `res_rd`, `bwr_vld`, `finish`) are low from that edge onward; counters are cleared.
  - A word transferred in the abort cycle is discarded; `op_we` is not asserted for it.
  - `abort` has priority over `start` in IDLE.

## Timing
- Reset values:
  - State IDLE; all outputs 0, including `frd_rdy`, `busy`, `bwr_dat`, `op_wdata`, `op_addr`, `op_sel` and `res_addr`.
  - Mid-frame reset discards the frame. FIFO contents are not this block's concern.
- `busy` rises on the edge entering LOAD and falls on the edge leaving DONE.
- Load throughput is 1 word/cycle when `frd_vld` is held high.
  - `op_we` trails each transfer by exactly 1 cycle.
  - `core_start` trails the last `op_we` by exactly 1 cycle.
- Result throughput is 3 cycles/word minimum (READ, CAP, PUSH) with `bwr_rdy=1`.
- Minimum frame, from `start` sampled to `finish`: 1 + 3·NW + 2 + W + 3·NW + 1 cycles, where W = cycles spent in WAIT (≥1).
- `finish` is the sole completion indication; the bridge must treat it as a pulse.

## Test plan
- **Basic frame (NW=2):**
  - Stimulus: push words 0x10..0x15 with `frd_vld` held; `core_done` 5 cycles after `core_start`; `res_rdata` = 0xA0+addr.
  - Response: `op_we` writes (sel,addr,data) = (0,0,10),(0,1,11),(1,0,12),(1,1,13),(2,0,14),(2,1,15) on consecutive cycles; one `core_start`; backward FIFO receives 0xA0, 0xA1; one `finish`.
- **Input gaps:** `frd_vld` toggled 1-0-1 per cycle → same six writes, each one cycle after its transfer; no duplicates, no pops while `frd_vld=0`.
- **Backpressure:** `bwr_rdy=0` for 7 cycles in the first PUSH → `bwr_vld` and `bwr_dat=0xA0` held stable for 8 cycles; exactly one accepted write.
- **Spurious inputs:**
  - `start` pulsed during WAIT, and `core_done` pulsed during LOAD → no effect.
  - Frame completes exactly as in the basic frame.
- **Abort:** `abort` asserted after the 3rd transfer → next cycle IDLE, `busy=0`, no further `op_we`. A following normal frame loads sel 0 addr 0 first.
- **Async reset:** `HRESET` pulse mid-PUSH (not clock-aligned) → all outputs 0 immediately; the next `start` runs a full clean frame.
